store_buf_ctrl: RTL and testbench

Controller for the store-buffer FIFO between the LSU and the data-memory bus. It accepts committed stores, pushes them into an external `fifo` instance, and drains the head entry to memory one transaction at a time. It also implements fence/flush sequencing. The FIFO's count updates on raw `wr_en`/`rd_en` without gating, so this block guarantees the FIFO never sees a push while full or a pop while empty.

---
 rtl/store_buf_ctrl_if.sv | 48 ++++
 rtl/store_buf_ctrl.sv | 109 ++++++++++
 tb/tb_store_buf_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buf_ctrl_if.sv
// Store-buffer controller bus bundle: LSU store channel, FIFO push/pop port and memory write channel.
// master = surrounding LSU/FIFO/bus environment, slave = the controller.
interface store_buf_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;
  localparam int EW = AW + DW + SW;

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [SW-1:0] st_strb;

  logic          fifo_wr_en;
  logic [EW-1:0] fifo_wdata;
  logic          fifo_rd_en;
  logic [EW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [SW-1:0] mem_strb;
  logic          mem_resp_valid;
  logic          mem_resp_err;

  modport master (
    output st_valid, st_addr, st_data, st_strb,
    input  st_ready,
    input  fifo_wr_en, fifo_wdata, fifo_rd_en,
    output fifo_rdata, fifo_full, fifo_empty,
    input  mem_req_valid, mem_addr, mem_data, mem_strb,
    output mem_req_ready, mem_resp_valid, mem_resp_err
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_strb,
    output st_ready,
    output fifo_wr_en, fifo_wdata, fifo_rd_en,
    input  fifo_rdata, fifo_full, fifo_empty,
    output mem_req_valid, mem_addr, mem_data, mem_strb,
    input  mem_req_ready, mem_resp_valid, mem_resp_err
  );
endinterface

// File: rtl/store_buf_ctrl.sv
// Store-buffer controller: gates pushes into an external FIFO, drains the head entry to memory
// one write at a time, and sequences fence/flush requests.
module store_buf_ctrl #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  store_buf_ctrl_if.slave        bus,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   busy,
  output logic                   err,
  output logic [AW-1:0]          err_addr
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                 state_reg;
  logic [$clog2(DEPTH):0] occ_reg;
  logic [$clog2(DEPTH):0] occ_next;
  logic                   flush_pend_reg;
  logic                   err_reg;
  logic [AW-1:0]          err_addr_reg;
  logic                   mem_req_valid_reg;
  logic                   push;
  logic                   pop;
  logic                   done;

  // The FIFO counts raw enables, so both are gated here against full/empty.
  assign bus.st_ready   = !bus.fifo_full && !flush_pend_reg;
  assign push           = bus.st_valid && bus.st_ready;
  assign bus.fifo_wr_en = push;
  assign bus.fifo_wdata = {bus.st_addr, bus.st_data, bus.st_strb};

  // Only a response in RESP retires the head entry; RESP implies occ >= 1.
  assign pop            = (state_reg == RESP) && bus.mem_resp_valid;
  assign bus.fifo_rd_en = pop;

  assign {bus.mem_addr, bus.mem_data, bus.mem_strb} = bus.fifo_rdata;
  assign bus.mem_req_valid = mem_req_valid_reg;

  assign done       = flush_pend_reg && (occ_reg == '0) && (state_reg == IDLE);
  assign flush_done = done;
  assign occ        = occ_reg;
  assign busy       = (occ_reg != '0) || (state_reg != IDLE);
  assign err        = err_reg;
  assign err_addr   = err_addr_reg;

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      occ_reg           <= '0;
      flush_pend_reg    <= 1'b0;
      err_reg           <= 1'b0;
      err_addr_reg      <= '0;
      mem_req_valid_reg <= 1'b0;
    end else begin
      occ_reg <= occ_next;
      case (state_reg)
        IDLE: begin
          if (!bus.fifo_empty) begin
            state_reg         <= REQ;
            mem_req_valid_reg <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state_reg         <= RESP;
            mem_req_valid_reg <= 1'b0;
          end
        end
        RESP: begin
          if (pop) begin
            // A push landing in the response cycle keeps the drain going without an IDLE bubble.
            if (occ_next != '0) begin
              state_reg         <= REQ;
              mem_req_valid_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
            if (bus.mem_resp_err) begin
              err_reg <= 1'b1;
              if (!err_reg) err_addr_reg <= bus.mem_addr;
            end
          end
        end
        default: begin
          state_reg         <= IDLE;
          mem_req_valid_reg <= 1'b0;
        end
      endcase

      // A request coinciding with completion is absorbed into the flush that is finishing.
      if (done)           flush_pend_reg <= 1'b0;
      else if (flush_req) flush_pend_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_store_buf_ctrl.sv
// Directed bench for store_buf_ctrl: behavioural FIFO, per-cycle vector table, and
// hand-written sequences for fill/flush/error/reset corners.
module tb_store_buf_ctrl;
  localparam int AW = 32, DW = 32, DEPTH = 4, EW = AW + DW + DW / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_req = 1'b0;
  logic       flush_done, busy, err;
  logic [2:0] occ;
  logic [31:0] err_addr;

  store_buf_ctrl_if #(.AW(AW), .DW(DW)) bif ();

  store_buf_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .flush_req(flush_req), .flush_done(flush_done),
    .occ(occ), .busy(busy), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: counts raw enables, exactly like the attached instance.
  logic [EW-1:0] fmem [DEPTH];
  logic [1:0]    wp, rp;
  logic [2:0]    fcnt;
  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; fcnt <= '0;
    end else begin
      if (bif.fifo_wr_en) begin fmem[wp] <= bif.fifo_wdata; wp <= wp + 2'd1; end
      if (bif.fifo_rd_en) rp <= rp + 2'd1;
      fcnt <= fcnt + {2'b0, bif.fifo_wr_en} - {2'b0, bif.fifo_rd_en};
    end
  end
  assign bif.fifo_rdata = fmem[rp];
  assign bif.fifo_full  = (fcnt == 3'(DEPTH));
  assign bif.fifo_empty = (fcnt == 3'd0);

  int n_cmp = 0, n_bad = 0, prot_bad = 0, fd_cnt = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    #2;
    if (bif.fifo_wr_en && bif.fifo_full)  prot_bad++;
    if (bif.fifo_rd_en && bif.fifo_empty) prot_bad++;
    if (flush_done) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction
  function automatic logic [3:0] strb_of(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 4'hF : (a[5:2] ^ 4'h9);
  endfunction

  task automatic drive_st(input logic [31:0] a);
    bif.st_valid = 1'b1;
    bif.st_addr  = a;
    bif.st_data  = dat_of(a);
    bif.st_strb  = strb_of(a);
  endtask

  task automatic push_store(input logic [31:0] a);
    @(negedge clk);
    drive_st(a);
    #1;
    check("push_wr_en", bif.fifo_wr_en, 1);
    exp_q.push_back(a);
    @(posedge clk); #1;
    bif.st_valid = 1'b0;
  endtask

  // Acts as the memory bus: ready always, response the cycle after the handshake.
  task automatic run_bus(input int n, input logic [7:0] err_mask, input int max_cyc, input bit st_closed);
    int  got = 0, c = 0;
    bit  aw = 0, drop;
    logic [31:0] ea;
    while (got < n && c < max_cyc) begin
      @(negedge clk);
      c++;
      drop = 0;
      bif.mem_req_ready  = 1'b1;
      bif.mem_resp_valid = aw;
      bif.mem_resp_err   = aw && err_mask[got];
      #1;
      if (st_closed) check("st_closed", bif.st_ready, 0);
      if (bif.st_valid && bif.fifo_wr_en) begin
        exp_q.push_back(bif.st_addr);
        drop = 1;
      end
      if (aw) begin
        check("resp_pop", bif.fifo_rd_en, 1);
        got++;
        aw = 0;
      end else if (bif.mem_req_valid) begin
        $display("bus write: addr=%08h data=%08h strb=%h", bif.mem_addr, bif.mem_data, bif.mem_strb);
        if (exp_q.size() == 0) begin
          check("unexpected_req", bif.mem_req_valid, 0);
        end else begin
          ea = exp_q.pop_front();
          check("bus_addr", bif.mem_addr, ea);
          check("bus_data", bif.mem_data, dat_of(ea));
          check("bus_strb", bif.mem_strb, strb_of(ea));
        end
        aw = 1;
      end
      @(posedge clk); #1;
      if (drop) bif.st_valid = 1'b0;
      bif.mem_resp_valid = 1'b0;
      bif.mem_resp_err   = 1'b0;
    end
    bif.mem_req_ready = 1'b0;
    check("bus_resp_count", got, n);
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] addr;
    logic        fl, rdy, rv;
    logic        x_sr, x_wr, x_mrv, x_rd, x_fd;
    logic [2:0]  x_occ;
    logic        x_busy;
    logic [31:0] x_maddr;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [31:0] a, input logic fl, input logic rdy,
                              input logic rv, input logic xsr, input logic xwr, input logic xmrv,
                              input logic xrd, input logic xfd, input logic [2:0] xocc,
                              input logic xbusy, input logic [31:0] xma);
    vec_t v;
    v.sv = sv; v.addr = a; v.fl = fl; v.rdy = rdy; v.rv = rv;
    v.x_sr = xsr; v.x_wr = xwr; v.x_mrv = xmrv; v.x_rd = xrd; v.x_fd = xfd;
    v.x_occ = xocc; v.x_busy = xbusy; v.x_maddr = xma;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    //              sv  addr           fl rdy rv | sr wr mrv rd fd occ busy maddr
    tbl[0]  = mk(1, 32'h8000_0010, 0, 1, 0,   1, 1, 0, 0, 0, 3'd0, 0, 32'h0);
    tbl[1]  = mk(0, 32'h0,         0, 1, 0,   1, 0, 0, 0, 0, 3'd1, 1, 32'h0);
    tbl[2]  = mk(0, 32'h0,         0, 1, 0,   1, 0, 1, 0, 0, 3'd1, 1, 32'h8000_0010);
    tbl[3]  = mk(0, 32'h0,         0, 0, 1,   1, 0, 0, 1, 0, 3'd1, 1, 32'h0);
    tbl[4]  = mk(0, 32'h0,         0, 0, 0,   1, 0, 0, 0, 0, 3'd0, 0, 32'h0);
    tbl[5]  = mk(0, 32'h0,         1, 0, 0,   1, 0, 0, 0, 0, 3'd0, 0, 32'h0);
    tbl[6]  = mk(0, 32'h0,         0, 0, 0,   0, 0, 0, 0, 1, 3'd0, 0, 32'h0);
    tbl[7]  = mk(0, 32'h0,         0, 0, 1,   1, 0, 0, 0, 0, 3'd0, 0, 32'h0);
    tbl[8]  = mk(1, 32'h200,       0, 0, 0,   1, 1, 0, 0, 0, 3'd0, 0, 32'h0);
    tbl[9]  = mk(1, 32'h204,       0, 0, 0,   1, 1, 0, 0, 0, 3'd1, 1, 32'h0);
    tbl[10] = mk(0, 32'h0,         0, 0, 0,   1, 0, 1, 0, 0, 3'd2, 1, 32'h200);
    tbl[11] = mk(0, 32'h0,         0, 1, 0,   1, 0, 1, 0, 0, 3'd2, 1, 32'h200);
    tbl[12] = mk(1, 32'h208,       0, 0, 1,   1, 1, 0, 1, 0, 3'd2, 1, 32'h0);
    tbl[13] = mk(0, 32'h0,         0, 1, 0,   1, 0, 1, 0, 0, 3'd2, 1, 32'h204);
    tbl[14] = mk(0, 32'h0,         0, 0, 1,   1, 0, 0, 1, 0, 3'd2, 1, 32'h0);
    tbl[15] = mk(0, 32'h0,         0, 1, 0,   1, 0, 1, 0, 0, 3'd1, 1, 32'h208);
    tbl[16] = mk(0, 32'h0,         0, 0, 1,   1, 0, 0, 1, 0, 3'd1, 1, 32'h0);
    tbl[17] = mk(0, 32'h0,         0, 0, 0,   1, 0, 0, 0, 0, 3'd0, 0, 32'h0);

    bif.st_valid = 0; bif.st_addr = '0; bif.st_data = '0; bif.st_strb = '0;
    bif.mem_req_ready = 0; bif.mem_resp_valid = 0; bif.mem_resp_err = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_st_ready", bif.st_ready, 1);
    check("rst_occ", occ, 0);
    check("rst_mrv", bif.mem_req_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_err", err, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", bif.fifo_wr_en, 0);
    check("rst_rd_en", bif.fifo_rd_en, 0);

    // Cycle vectors: single store, empty flush, stray response, push+pop at occ=2
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bif.st_valid = tbl[i].sv;
      bif.st_addr = tbl[i].addr; bif.st_data = dat_of(tbl[i].addr); bif.st_strb = strb_of(tbl[i].addr);
      flush_req = tbl[i].fl;
      bif.mem_req_ready = tbl[i].rdy;
      bif.mem_resp_valid = tbl[i].rv;
      bif.mem_resp_err = 1'b0;
      #1;
      $display("vec %0d: st_ready=%0b wr=%0b mrv=%0b rd=%0b fd=%0b occ=%0d busy=%0b",
               i, bif.st_ready, bif.fifo_wr_en, bif.mem_req_valid, bif.fifo_rd_en, flush_done, occ, busy);
      check($sformatf("v%0d_st_ready", i), bif.st_ready, tbl[i].x_sr);
      check($sformatf("v%0d_wr_en", i), bif.fifo_wr_en, tbl[i].x_wr);
      check($sformatf("v%0d_mrv", i), bif.mem_req_valid, tbl[i].x_mrv);
      check($sformatf("v%0d_rd_en", i), bif.fifo_rd_en, tbl[i].x_rd);
      check($sformatf("v%0d_flush_done", i), flush_done, tbl[i].x_fd);
      check($sformatf("v%0d_occ", i), occ, tbl[i].x_occ);
      check($sformatf("v%0d_busy", i), busy, tbl[i].x_busy);
      if (tbl[i].x_mrv) begin
        check($sformatf("v%0d_mem_addr", i), bif.mem_addr, tbl[i].x_maddr);
        check($sformatf("v%0d_mem_data", i), bif.mem_data, dat_of(tbl[i].x_maddr));
        check($sformatf("v%0d_mem_strb", i), bif.mem_strb, strb_of(tbl[i].x_maddr));
      end
    end
    @(negedge clk);
    bif.st_valid = 0; flush_req = 0; bif.mem_req_ready = 0; bif.mem_resp_valid = 0;

    // Fill to DEPTH with the bus stalled, hold off a 5th store, then drain in order
    for (int i = 0; i < 4; i++) push_store(32'h300 + 32'(4 * i));
    @(negedge clk);
    drive_st(32'h310);
    #1;
    check("full_occ", occ, 4);
    check("full_st_ready", bif.st_ready, 0);
    check("full_hold_wr", bif.fifo_wr_en, 0);
    repeat (2) begin
      @(negedge clk); #1;
      check("full_hold_wr", bif.fifo_wr_en, 0);
    end
    @(posedge clk); #1;
    run_bus(5, 8'h00, 60, 0);
    check("full_all_drained", exp_q.size(), 0);
    check("full_st_valid_taken", bif.st_valid, 0);

    // Flush with three queued entries plus a store in the flush cycle
    push_store(32'h500); push_store(32'h504); push_store(32'h508);
    @(negedge clk);
    drive_st(32'h50C);
    flush_req = 1'b1;
    #1;
    check("flush_same_cycle_wr", bif.fifo_wr_en, 1);
    exp_q.push_back(32'h50C);
    @(posedge clk); #1;
    bif.st_valid = 0; flush_req = 0;
    begin
      int fd0;
      fd0 = fd_cnt;
      run_bus(4, 8'h00, 60, 1);
      check("flush_all_issued", exp_q.size(), 0);
      @(negedge clk); #1;
      check("flush_done_pulse", flush_done, 1);
      check("flush_st_ready_closed", bif.st_ready, 0);
      @(negedge clk); #1;
      check("flush_done_single", flush_done, 0);
      check("flush_st_ready_reopen", bif.st_ready, 1);
      check("flush_done_count", fd_cnt - fd0, 1);
    end

    // Bus error on the 2nd of 3 stores, then a later error
    push_store(32'h100); push_store(32'h104); push_store(32'h108);
    run_bus(3, 8'b010, 60, 0);
    check("err_set", err, 1);
    check("err_addr_first", err_addr, 32'h104);
    check("err_third_issued", exp_q.size(), 0);
    push_store(32'h10C);
    run_bus(1, 8'b1, 30, 0);
    check("err_sticky", err, 1);
    check("err_addr_kept", err_addr, 32'h104);

    // Reset while waiting for a response
    push_store(32'h400);
    begin
      int w = 0;
      @(negedge clk); #1;
      while (!bif.mem_req_valid && w < 10) begin @(negedge clk); #1; w++; end
      check("rst_test_req", bif.mem_req_valid, 1);
    end
    bif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bif.mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("resp_busy", busy, 1);
    @(negedge clk); #1;
    check("midrst_mrv", bif.mem_req_valid, 0);
    check("midrst_occ", occ, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_err_addr", err_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("midrst_idle_mrv", bif.mem_req_valid, 0);

    check("fifo_protocol", prot_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
